pipe_cla_adder: RTL and testbench

PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

---
 rtl/cla_pkg.sv | 25 ++
 rtl/cla_slice.sv | 71 +++++++
 rtl/pipe_cla_adder.sv | 176 +++++++++++++++++
 tb/tb_pipe_cla_adder.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// ---------------------------------------------------------------------------
// cla_pkg
// Shared constants for the pipelined carry-lookahead adder.
//   GROUP_SIZE  : width of one generate/propagate lookahead group
//   MIN_WIDTH   : smallest operand width the adder supports
//   MIN_STAGES  : smallest pipeline depth
//   paramsLegal : true when a WIDTH/STAGES pair can be built
// ---------------------------------------------------------------------------
package cla_pkg;

    localparam int GROUP_SIZE = 4;
    localparam int MIN_WIDTH  = 8;
    localparam int MIN_STAGES = 1;

    // Width must be whole groups, and the groups must split evenly over
    // the stages so that every stage owns the same number of groups.
    function automatic bit paramsLegal(input int width, input int stages);
        return (width >= MIN_WIDTH) &&
               ((width % GROUP_SIZE) == 0) &&
               (stages >= MIN_STAGES) &&
               (stages <= width / GROUP_SIZE) &&
               (((width / GROUP_SIZE) % stages) == 0);
    endfunction

endpackage

// File: rtl/cla_slice.sv
// ---------------------------------------------------------------------------
// cla_slice
// Combinational W-bit carry-lookahead adder built from 4-bit groups.
// Carries are fully looked-ahead inside each group; group carries chain
// from one group to the next.
//   a_i, b_i : operand slices (b_i already inverted for subtraction)
//   cin_i    : carry into bit 0 of the slice
//   sum_o    : slice sum
//   cout_o   : carry out of the slice MSB
//   cmsb_o   : carry into the slice MSB (used for signed overflow)
// ---------------------------------------------------------------------------
module cla_slice
    import cla_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o,
    output logic         cmsb_o
);

    localparam int NG = W / GROUP_SIZE;

    logic [W-1:0]          gen;
    logic [W-1:0]          prop;
    logic [W-1:0]          carry;
    logic [NG:0]           groupCarry;
    logic [GROUP_SIZE-1:0] gg;
    logic [GROUP_SIZE-1:0] pp;
    logic                  c0;
    logic                  grpG;
    logic                  grpP;

    // Per-group lookahead: the three internal carries and the group
    // generate/propagate are flattened sum-of-products of the group's
    // bit generates/propagates and the group carry-in.
    always_comb begin
        gen           = a_i & b_i;
        prop          = a_i ^ b_i;
        carry         = '0;
        groupCarry    = '0;
        groupCarry[0] = cin_i;
        gg            = '0;
        pp            = '0;
        c0            = 1'b0;
        grpG          = 1'b0;
        grpP          = 1'b0;
        for (int j = 0; j < NG; j++) begin
            gg = gen[j*GROUP_SIZE +: GROUP_SIZE];
            pp = prop[j*GROUP_SIZE +: GROUP_SIZE];
            c0 = groupCarry[j];
            carry[j*GROUP_SIZE + 0] = c0;
            carry[j*GROUP_SIZE + 1] = gg[0] | (pp[0] & c0);
            carry[j*GROUP_SIZE + 2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c0);
            carry[j*GROUP_SIZE + 3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                                    | (pp[2] & pp[1] & pp[0] & c0);
            grpG = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                 | (pp[3] & pp[2] & pp[1] & gg[0]);
            grpP = &pp;
            groupCarry[j+1] = grpG | (grpP & c0);
        end
    end

    assign sum_o  = prop ^ carry;
    assign cout_o = groupCarry[NG];
    assign cmsb_o = carry[W-1];

endmodule

// File: rtl/pipe_cla_adder.sv
// ---------------------------------------------------------------------------
// pipe_cla_adder
// Pipelined add/subtract unit. The operands are cut into STAGES slices;
// stage k adds slice k with a cla_slice and registers its carry-out for
// stage k+1. Untouched upper operand slices ride along with each token and
// finished lower sum slices are carried forward in the stage registers.
// Valid/ready handshake on both sides, one result per cycle, latency of
// STAGES cycles.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid, in_ready    : operand handshake (in_ready ignores in_valid)
//   A, B, Cin, sub        : operands, carry-in (ignored when sub=1), subtract
//   out_valid, out_ready  : result handshake
//   S, Cout, Ovfl, Zero   : result, carry-out (no-borrow for sub),
//                           signed overflow, result-is-zero
// Optional feature: define PIPE_CLA_ADDER_SAT_EN to saturate S on signed
// overflow instead of wrapping.
// ---------------------------------------------------------------------------
module pipe_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovfl,
    output logic             Zero
);

    localparam int SW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    if (!paramsLegal(WIDTH, STAGES)) begin : g_badParams
        $error("pipe_cla_adder: illegal WIDTH/STAGES combination");
    end

    // Stage registers: token valid, operands, partial sum, slice carries.
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] carry_q;
    logic [STAGES-1:0] msbCarry_q;
    logic [WIDTH-1:0]  opA_q [STAGES];
    logic [WIDTH-1:0]  opB_q [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];

    // Values presented to each stage's adder and their next-state forms.
    logic [STAGES-1:0] stageValid;
    logic [STAGES-1:0] stageCin;
    logic [WIDTH-1:0]  stageA   [STAGES];
    logic [WIDTH-1:0]  stageB   [STAGES];
    logic [WIDTH-1:0]  stageSum [STAGES];
    logic [WIDTH-1:0]  sum_d    [STAGES];
    logic [SW-1:0]     sliceSum [STAGES];
    logic [STAGES-1:0] sliceCout;
    logic [STAGES-1:0] sliceCmsb;
    logic [STAGES:0]   advance;

    // A stage may take a new token when it is empty or its current token
    // is leaving; the chain starts at the consumer's out_ready.
    always_comb begin
        advance         = '0;
        advance[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            advance[k] = !valid_q[k] || advance[k+1];
        end
    end

    assign in_ready = advance[0];

    // Stage 0 takes the raw operands; subtraction is folded in here as
    // A + ~B + 1 so every later stage is a plain adder.
    always_comb begin
        stageValid = '0;
        stageCin   = '0;
        for (int k = 0; k < STAGES; k++) begin
            stageA[k]   = '0;
            stageB[k]   = '0;
            stageSum[k] = '0;
        end
        stageValid[0] = in_valid;
        stageCin[0]   = sub ? 1'b1 : Cin;
        stageA[0]     = A;
        stageB[0]     = sub ? ~B : B;
        for (int k = 1; k < STAGES; k++) begin
            stageValid[k] = valid_q[k-1];
            stageCin[k]   = carry_q[k-1];
            stageA[k]     = opA_q[k-1];
            stageB[k]     = opB_q[k-1];
            stageSum[k]   = sum_q[k-1];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        cla_slice #(
            .W (SW)
        ) u_slice (
            .a_i    (stageA[g][g*SW +: SW]),
            .b_i    (stageB[g][g*SW +: SW]),
            .cin_i  (stageCin[g]),
            .sum_o  (sliceSum[g]),
            .cout_o (sliceCout[g]),
            .cmsb_o (sliceCmsb[g])
        );
    end

    // Each stage drops its freshly computed slice into the running sum.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            sum_d[k]              = stageSum[k];
            sum_d[k][k*SW +: SW]  = sliceSum[k];
        end
    end

    // Data registers only load real tokens, so a bubble never disturbs
    // the visible result and a stalled output holds naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            carry_q    <= '0;
            msbCarry_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                opA_q[k] <= '0;
                opB_q[k] <= '0;
                sum_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (advance[k]) begin
                    valid_q[k] <= stageValid[k];
                end
                if (advance[k] && stageValid[k]) begin
                    opA_q[k]      <= stageA[k];
                    opB_q[k]      <= stageB[k];
                    sum_q[k]      <= sum_d[k];
                    carry_q[k]    <= sliceCout[k];
                    msbCarry_q[k] <= sliceCmsb[k];
                end
            end
        end
    end

    logic [WIDTH-1:0] rawSum;

    assign rawSum    = sum_q[LAST];
    assign out_valid = valid_q[LAST];
    assign Cout      = carry_q[LAST];
    assign Ovfl      = msbCarry_q[LAST] ^ carry_q[LAST];

`ifdef PIPE_CLA_ADDER_SAT_EN
    // Overflow with a carry into the MSB but none out means two positives
    // wrapped negative; the opposite pattern means two negatives wrapped.
    always_comb begin
        S = rawSum;
        if (msbCarry_q[LAST] && !carry_q[LAST]) begin
            S = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (!msbCarry_q[LAST] && carry_q[LAST]) begin
            S = {1'b1, {(WIDTH-1){1'b0}}};
        end
    end
`else
    assign S = rawSum;
`endif

    // Qualified by out_valid so Zero reads 0 out of reset and between tokens.
    assign Zero = out_valid && (S == '0);

endmodule

// File: tb/tb_pipe_cla_adder.sv
// ---------------------------------------------------------------------------
// tb_pipe_cla_adder
// Drives a 16-bit/2-stage and a 32-bit/4-stage pipe_cla_adder. Expected
// results come from an arithmetic reference model and are queued on
// acceptance; a negedge monitor pops and compares whenever a result leaves.
// ---------------------------------------------------------------------------
module tb_pipe_cla_adder;

   typedef struct packed {
      logic [31:0] s;
      logic        cout;
      logic        ovfl;
      logic        zero;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] aIn;
   logic [31:0] bIn;
   logic        cinIn;
   logic        subIn;
   logic        inValid16;
   logic        inValid32;
   logic        outReady;
   logic        randBp;

   logic        inReady16, outValid16, cout16, ovfl16, zero16;
   logic [15:0] s16;
   logic        inReady32, outValid32, cout32, ovfl32, zero32;
   logic [31:0] s32;

   exp_t q16[$];
   exp_t q32[$];
   int   sent16 = 0;
   int   sent32 = 0;
   int   recv16 = 0;
   int   recv32 = 0;
   int   checks = 0;
   int   errors = 0;
   bit          prevStall [2];
   logic [31:0] prevS [2];

   pipe_cla_adder #(.WIDTH(16), .STAGES(2)) dut16 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (inValid16),
      .in_ready  (inReady16),
      .A         (aIn[15:0]),
      .B         (bIn[15:0]),
      .Cin       (cinIn),
      .sub       (subIn),
      .out_valid (outValid16),
      .out_ready (outReady),
      .S         (s16),
      .Cout      (cout16),
      .Ovfl      (ovfl16),
      .Zero      (zero16)
   );

   pipe_cla_adder #(.WIDTH(32), .STAGES(4)) dut32 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (inValid32),
      .in_ready  (inReady32),
      .A         (aIn),
      .B         (bIn),
      .Cin       (cinIn),
      .sub       (subIn),
      .out_valid (outValid32),
      .out_ready (outReady),
      .S         (s32),
      .Cout      (cout32),
      .Ovfl      (ovfl32),
      .Zero      (zero32)
   );

   always #5 clk = ~clk;

   // Reference: exact integer arithmetic on the operand values, with
   // signed overflow judged by whether the true signed result fits.
   function automatic exp_t refModel(input int w, input logic [31:0] a, input logic [31:0] b,
                                     input logic cin, input logic sub);
      exp_t   r;
      longint modv    = longint'(1) << w;
      longint half    = modv >> 1;
      longint ua      = longint'(a) % modv;
      longint ub      = longint'(b) % modv;
      longint bEff    = sub ? (modv - 1 - ub) : ub;
      longint c       = sub ? 64'd1 : longint'(cin);
      longint full    = ua + bEff + c;
      longint wrapped = full % modv;
      longint sa      = (ua >= half) ? ua - modv : ua;
      longint sb      = (ub >= half) ? ub - modv : ub;
      longint trueVal = sub ? sa - sb : sa + sb + longint'(cin);
      r.cout = (full >= modv);
      r.ovfl = (trueVal >= half) || (trueVal < -half);
`ifdef PIPE_CLA_ADDER_SAT_EN
      if (r.ovfl) wrapped = (trueVal > 0) ? half - 1 : half;
`endif
      r.s    = 32'(wrapped);
      r.zero = (wrapped == 0);
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Present one operand pair to the chosen adder and hold it until taken.
   task automatic applyStimulus(input int which, input logic [31:0] a, input logic [31:0] b,
                                input logic cin, input logic sub);
      int waited = 0;
      aIn = a;
      bIn = b;
      cinIn = cin;
      subIn = sub;
      if (which == 0) inValid16 = 1'b1;
      else inValid32 = 1'b1;
      forever begin
         @(negedge clk);
         if ((which == 0) ? inReady16 : inReady32) break;
         waited++;
         if (waited > 200) begin
            checks++;
            errors++;
            $display("[TB] FAIL acceptTimeout dut=%0d actual=stalled required=accepted", which);
            break;
         end
      end
      if (which == 0) begin
         q16.push_back(refModel(16, a, b, cin, sub));
         sent16++;
      end else begin
         q32.push_back(refModel(32, a, b, cin, sub));
         sent32++;
      end
      @(posedge clk);
      #1;
      inValid16 = 1'b0;
      inValid32 = 1'b0;
   endtask

   // Pops on every retiring result and verifies held outputs under stall.
   task automatic checkOutput(input int which, input logic valid, input logic [31:0] s,
                              input logic c, input logic o, input logic z);
      exp_t e;
      if (prevStall[which]) begin
         check($sformatf("holdStable%0d", which), {valid, s}, {1'b1, prevS[which]});
      end
      if (valid && outReady) begin
         if ((which == 0) ? (q16.size() == 0) : (q32.size() == 0)) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedOutput dut=%0d actual=S:%h required=no output", which, s);
         end else begin
            if (which == 0) begin
               e = q16.pop_front();
               recv16++;
            end else begin
               e = q32.pop_front();
               recv32++;
            end
            check($sformatf("result%0d", which), {s, c, o, z}, e);
         end
      end
      prevStall[which] = valid && !outReady;
      prevS[which] = s;
   endtask

   always @(negedge clk) begin
      if (rst) begin
         prevStall[0] = 1'b0;
         prevStall[1] = 1'b0;
      end else begin
         checkOutput(0, outValid16, {16'h0, s16}, cout16, ovfl16, zero16);
         checkOutput(1, outValid32, s32, cout32, ovfl32, zero32);
      end
   end

   always @(posedge clk) begin
      if (randBp) begin
         #1;
         outReady = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lat;
      int waitCycles;
      rst = 1'b1;
      aIn = '0;
      bIn = '0;
      cinIn = 1'b0;
      subIn = 1'b0;
      inValid16 = 1'b0;
      inValid32 = 1'b0;
      outReady = 1'b1;
      randBp = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      check("reset16", {outValid16, s16, cout16, ovfl16, zero16, inReady16},
            {1'b0, 16'h0, 3'b000, 1'b1});
      check("reset32", {outValid32, s32, cout32, ovfl32, zero32, inReady32},
            {1'b0, 32'h0, 3'b000, 1'b1});

      // Simple carry across the slice boundary, with latency measurement.
      @(posedge clk); #1;
      applyStimulus(0, 32'h00FF, 32'h0001, 1'b0, 1'b0);
      lat = 1;
      while (!outValid16 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check("latency16", lat, 2);

      applyStimulus(0, 32'h7FFF, 32'h0001, 1'b0, 1'b0);
      applyStimulus(0, 32'h1234, 32'h1234, 1'b1, 1'b1);
      applyStimulus(0, 32'h8000, 32'h0001, 1'b0, 1'b1);
      applyStimulus(0, 32'hFFFF, 32'h0000, 1'b1, 1'b0);
      repeat (4) @(posedge clk);
      #1;

      // Wide configuration: carry must ripple through all four stages.
      applyStimulus(1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
      lat = 1;
      while (!outValid32 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check("latency32", lat, 4);
      repeat (6) @(posedge clk);
      #1;

      // Back-to-back stream with a three-cycle consumer stall mid-stream.
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               applyStimulus(0, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
         end
         begin
            waitCycles = 0;
            while (sent16 < 10 && waitCycles < 100) begin
               @(posedge clk);
               waitCycles++;
            end
            #1 outReady = 1'b0;
            @(negedge clk);
            check("inReadyFull", inReady16, 1'b0);
            repeat (3) @(posedge clk);
            #1 outReady = 1'b1;
         end
      join
      repeat (6) @(posedge clk);
      #1;

      // Reset with two tokens in flight; neither may ever appear.
      outReady = 1'b0;
      applyStimulus(0, 32'h1111, 32'h2222, 1'b0, 1'b0);
      applyStimulus(0, 32'h3333, 32'h4444, 1'b0, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      q16.delete();
      sent16 -= 2;
      check("afterReset", {outValid16, s16, inReady16}, {1'b0, 16'h0, 1'b1});
      outReady = 1'b1;
      repeat (6) @(posedge clk);
      #1;

      // Randomized traffic with random consumer backpressure.
      randBp = 1'b1;
      for (int i = 0; i < 40; i++) begin
         applyStimulus(0, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
      end
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      @(posedge clk);
      randBp = 1'b0;
      #2 outReady = 1'b1;

      waitCycles = 0;
      while ((q16.size() != 0 || q32.size() != 0) && waitCycles < 200) begin
         @(posedge clk);
         waitCycles++;
      end
      repeat (2) @(posedge clk);
      check("drained16", q16.size(), 0);
      check("drained32", q32.size(), 0);
      check("count16", recv16, sent16);
      check("count32", recv32, sent32);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
